// File: rtl/mmio_port_unit.sv
// Memory-mapped I/O port: byte output FIFO drained by valid/ready, plus a
// one-entry input holding register, all reached through the core's load/store bus.
module mmio_port_unit #(
  parameter logic [31:0] PORT_BASE  = 32'h1001_0100,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Hit,
  input  logic [7:0]  PortIn,
  input  logic        PortInValid,
  output logic [7:0]  PortOut,
  output logic        PortOutValid,
  input  logic        PortOutReady
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_drop_q, out_drop_d;
  logic [7:0]    in_byte_q, in_byte_d;
  logic          in_valid_q, in_valid_d;
  logic          in_overrun_q, in_overrun_d;

  logic [1:0]    off;
  logic          wr_out, wr_ctrl, pop_in, flush, clr_flags;
  logic          out_empty, out_full, pop_out, push_ok;
  logic [31:0]   status;

  // Only the low byte of store data and the word offset are meaningful.
  logic unused_bits;
  assign unused_bits = ^{WriteData[31:8], Address[1:0]};

  assign Hit       = (Address[31:4] == PORT_BASE[31:4]);
  assign off       = Address[3:2];
  assign wr_out    = MemWrite & Hit & (off == 2'd0);
  assign wr_ctrl   = MemWrite & Hit & (off == 2'd3);
  assign pop_in    = MemRead  & Hit & (off == 2'd1);
  assign flush     = wr_ctrl & WriteData[0];
  assign clr_flags = wr_ctrl & WriteData[1];

  assign out_empty    = (count_q == '0);
  assign out_full     = (count_q == CW'(FIFO_DEPTH));
  assign PortOutValid = ~out_empty;
  assign PortOut      = mem_q[rd_ptr_q];
  assign pop_out      = PortOutValid & PortOutReady;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push_ok      = wr_out & (~out_full | pop_out);

  always_comb begin
    status          = '0;
    status[0]       = out_empty;
    status[1]       = out_full;
    status[2]       = in_valid_q;
    status[3]       = in_overrun_q;
    status[4]       = out_drop_q;
    status[8 +: CW] = count_q;
  end

  always_comb begin
    ReadData = '0;
    if (MemRead && Hit) begin
      case (off)
        2'd1:    ReadData = {24'b0, in_byte_q};
        2'd2:    ReadData = status;
        default: ReadData = '0;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_drop_d   = out_drop_q;
    in_byte_d    = in_byte_q;
    in_valid_d   = in_valid_q;
    in_overrun_d = in_overrun_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_out) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_out})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (wr_out && out_full && !pop_out) out_drop_d = 1'b1;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    if (clr_flags) begin
      out_drop_d   = 1'b0;
      in_overrun_d = 1'b0;
    end

    // A fresh overrun in the clearing cycle is still recorded.
    if (PortInValid) begin
      if (!in_valid_q || pop_in) begin
        in_byte_d  = PortIn;
        in_valid_d = 1'b1;
      end else begin
        in_overrun_d = 1'b1;
      end
    end else if (pop_in) begin
      in_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_drop_q   <= 1'b0;
      in_byte_q    <= '0;
      in_valid_q   <= 1'b0;
      in_overrun_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_drop_q   <= out_drop_d;
      in_byte_q    <= in_byte_d;
      in_valid_q   <= in_valid_d;
      in_overrun_q <= in_overrun_d;
    end
  end

  // Storage is cleared on reset so the head reads 0 until the first push.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (reset) mem_q[i] <= '0;
      else if (push_ok && (wr_ptr_q == AW'(i))) mem_q[i] <= WriteData[7:0];
    end
  end
endmodule

// File: tb/tb_mmio_port_unit.sv
// Scoreboard bench for mmio_port_unit: directed scenarios followed by random bus,
// input-strobe and consumer-ready traffic checked against a queue-based model.
module tb_mmio_port_unit;
  localparam int unsigned     DEPTH = 8;
  localparam logic [31:0]     BASE  = 32'h1001_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address, WriteData, ReadData;
  logic        MemWrite, MemRead, Hit;
  logic [7:0]  PortIn, PortOut;
  logic        PortInValid, PortOutValid, PortOutReady;

  int n_checks = 0;
  int n_fail   = 0;

  byte unsigned   exp_q[$];      // model of the output FIFO contents, head first
  logic [31:0]    rd_exp_q[$];   // expected ReadData for each issued load
  logic [7:0]     m_in_byte;
  logic           m_in_valid, m_overrun, m_drop;

  mmio_port_unit #(.PORT_BASE(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData), .Hit(Hit),
    .PortIn(PortIn), .PortInValid(PortInValid), .PortOut(PortOut),
    .PortOutValid(PortOutValid), .PortOutReady(PortOutReady)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] st;
    int          cnt;
    if (a[31:4] != BASE[31:4]) return 32'h0;
    cnt = exp_q.size();
    st  = 32'h0;
    st[0]    = (cnt == 0);
    st[1]    = (cnt == DEPTH);
    st[2]    = m_in_valid;
    st[3]    = m_overrun;
    st[4]    = m_drop;
    st[12:8] = 5'(cnt);
    case (a[3:2])
      2'd1:    return {24'h0, m_in_byte};
      2'd2:    return st;
      default: return 32'h0;
    endcase
  endfunction

  // One bus cycle; called 1 time unit after a rising edge, returns likewise.
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic mw,
                      input logic mr, input logic pinv, input logic [7:0] pin,
                      input logic rdy);
    int   size0;
    logic hit, pop_m, pop_in;
    Address = a; WriteData = wd; MemWrite = mw; MemRead = mr;
    PortInValid = pinv; PortIn = pin; PortOutReady = rdy;
    hit    = (a[31:4] == BASE[31:4]);
    size0  = exp_q.size();
    pop_m  = rdy && (size0 > 0);
    pop_in = mr && hit && (a[3:2] == 2'd1);
    if (mr) rd_exp_q.push_back(model_read(a));
    @(posedge clk);
    if (mw && hit && a[3:2] == 2'd0) begin
      if (size0 < DEPTH || pop_m) exp_q.push_back(wd[7:0]);
      else m_drop = 1'b1;
    end
    if (mw && hit && a[3:2] == 2'd3) begin
      if (wd[0]) exp_q.delete();
      if (wd[1]) begin m_drop = 1'b0; m_overrun = 1'b0; end
    end
    if (pinv) begin
      if (!m_in_valid || pop_in) begin m_in_byte = pin; m_in_valid = 1'b1; end
      else m_overrun = 1'b1;
    end else if (pop_in) begin
      m_in_valid = 1'b0;
    end
    #1;
  endtask

  task automatic wr(input logic [1:0] o, input logic [31:0] d, input logic rdy);
    step(BASE + 32'(o) * 4, d, 1'b1, 1'b0, 1'b0, 8'h0, rdy);
  endtask
  task automatic rd(input logic [1:0] o, input logic rdy);
    step(BASE + 32'(o) * 4, 32'h0, 1'b0, 1'b1, 1'b0, 8'h0, rdy);
  endtask
  task automatic idle(input logic rdy);
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0, rdy);
  endtask
  task automatic strobe_in(input logic [7:0] b);
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, b, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    Address = 32'h0; WriteData = 32'h0; MemWrite = 1'b0; MemRead = 1'b0;
    PortInValid = 1'b0; PortIn = 8'h0; PortOutReady = 1'b0;
    @(posedge clk);
    exp_q.delete();
    m_in_byte = 8'h0; m_in_valid = 1'b0; m_overrun = 1'b0; m_drop = 1'b0;
    #1;
    reset = 1'b0;
    chk("portout_after_reset", {24'h0, PortOut}, 32'h0);
    chk("valid_after_reset", {31'h0, PortOutValid}, 32'h0);
  endtask

  // Monitor: compares FIFO output and load data against the scoreboard queues.
  initial begin
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) continue;
      chk("out_valid", {31'h0, PortOutValid}, {31'h0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        chk("out_data", {24'h0, PortOut}, {24'h0, exp_q[0]});
        if (PortOutReady) void'(exp_q.pop_front());
      end
      if (MemRead) begin
        if (rd_exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL read_queue: got load with no expectation at %0t", $time);
        end else begin
          chk("read_data", ReadData, rd_exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int op;
    logic [1:0] o;
    do_reset();
    rd(2'd2, 1'b0);

    // T1: single store becomes visible next cycle
    wr(2'd0, 32'hA5, 1'b0);
    rd(2'd2, 1'b0);
    wr(2'd3, 32'h1, 1'b0);

    // T2: overfill with ready low, then drain
    for (int i = 1; i <= 9; i++) wr(2'd0, 32'(i), 1'b0);
    rd(2'd2, 1'b0);
    for (int i = 0; i < 8; i++) idle(1'b1);
    rd(2'd2, 1'b0);
    wr(2'd3, 32'h2, 1'b0);

    // T3: push into full FIFO while the head is taken
    for (int i = 0; i < 8; i++) wr(2'd0, 32'h10 + 32'(i), 1'b0);
    wr(2'd0, 32'h55, 1'b1);
    rd(2'd2, 1'b0);
    for (int i = 0; i < 9; i++) idle(1'b1);
    rd(2'd2, 1'b0);

    // T4: input holding register, overrun and clear
    strobe_in(8'h3C);
    rd(2'd2, 1'b0);
    rd(2'd1, 1'b0);
    rd(2'd2, 1'b0);
    strobe_in(8'h11);
    strobe_in(8'h22);
    rd(2'd2, 1'b0);
    wr(2'd3, 32'h2, 1'b0);
    rd(2'd2, 1'b0);
    rd(2'd1, 1'b0);
    rd(2'd1, 1'b0);
    step(BASE + 32'h4, 32'h0, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0);
    rd(2'd2, 1'b0);

    // T5: flush with ready high leaves input side alone
    for (int i = 0; i < 3; i++) wr(2'd0, 32'hC0 + 32'(i), 1'b0);
    wr(2'd3, 32'h1, 1'b1);
    rd(2'd2, 1'b0);

    // Wrong-direction and out-of-window accesses
    rd(2'd0, 1'b0);
    rd(2'd3, 1'b0);
    wr(2'd1, 32'hFF, 1'b0);
    wr(2'd2, 32'hFF, 1'b0);
    step(BASE + 32'h10, 32'h99, 1'b1, 1'b0, 1'b0, 8'h0, 1'b0);
    step(BASE + 32'h18, 32'h0, 1'b0, 1'b1, 1'b0, 8'h0, 1'b0);
    rd(2'd2, 1'b0);

    // T6: reset mid-traffic
    for (int i = 0; i < 4; i++) wr(2'd0, 32'hE0 + 32'(i), 1'b0);
    strobe_in(8'h5A);
    do_reset();
    rd(2'd2, 1'b0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      op = int'($urandom_range(0, 9));
      o  = 2'($urandom_range(0, 3));
      case (op)
        0, 1, 2: step(BASE + 32'h0 + 32'($urandom_range(0, 3)), $urandom, 1'b1, 1'b0,
                      1'($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom));
        3:       step(BASE + 32'h4 + 32'($urandom_range(0, 3)), 32'h0, 1'b0, 1'b1,
                      1'($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom));
        4, 5:    step(BASE + 32'h8, 32'h0, 1'b0, 1'b1,
                      1'($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom));
        6:       step(BASE + 32'hC, 32'($urandom_range(0, 3)) & (($urandom_range(0, 3) == 0) ? 32'h3 : 32'h2),
                      1'b1, 1'b0, 1'b0, 8'h0, 1'($urandom));
        7:       step((($urandom_range(0, 1) == 1) ? BASE + 32'h20 : BASE) + 32'(o) * 4, $urandom,
                      1'($urandom), 1'b0, 1'($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom));
        default: step(32'h0, 32'h0, 1'b0, 1'b0, 1'($urandom_range(0, 2) == 0),
                      8'($urandom), 1'($urandom));
      endcase
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    rd(2'd2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
